// File: rtl/shift_arbiter_if.sv
// Request/response bundle between two shift requesters, the shared shifter and its consumer.
// Requesters and the consumer sit on the master side; the arbiter takes the slave modport.
interface shift_arbiter_if;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a_d;
  logic [2:0] a_s;
  logic [1:0] a_t;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] b_d;
  logic [2:0] b_s;
  logic [1:0] b_t;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_q;
  logic       rsp_id;

  modport master (
    output a_valid, a_d, a_s, a_t,
    output b_valid, b_d, b_s, b_t,
    output rsp_ready,
    input  a_ready, b_ready, rsp_valid, rsp_q, rsp_id
  );

  modport slave (
    input  a_valid, a_d, a_s, a_t,
    input  b_valid, b_d, b_s, b_t,
    input  rsp_ready,
    output a_ready, b_ready, rsp_valid, rsp_q, rsp_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 8-bit barrel shifter between requesters A and B,
// with a one-entry registered response buffer. Define SHIFT_STATS_EN for saturating grant counters.
module shift_arbiter
`ifdef SHIFT_STATS_EN
  #(parameter int CNT_W = 16)
`endif
(
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave bus
`ifdef SHIFT_STATS_EN
  ,
  output logic [CNT_W-1:0] a_grants,
  output logic [CNT_W-1:0] b_grants
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state, state_nxt;
  logic       prio;
  logic       can_issue;
  logic       contested;
  logic       grant_a;
  logic       grant_b;
  logic       grant;
  logic [7:0] sel_d_p0;
  logic [2:0] sel_s_p0;
  logic [1:0] sel_t_p0;
  logic [7:0] shift_p0;
  logic [7:0] q_p1;
  logic       id_p1;

  // t[1]=1 selects left (covers 11); 00 logical right; 01 arithmetic right.
  function automatic logic [7:0] barrel_shift(input logic [7:0] d, input logic [2:0] s,
                                              input logic [1:0] t);
    logic signed [7:0] sd;
    logic [7:0]        r;
    sd = d;
    if (t[1])       r = d << s;
    else if (!t[0]) r = d >> s;
    else            r = sd >>> s;
    return r;
  endfunction

  // Stage p0: arbitration, operand select and shift
  always_comb begin
    state_nxt = state;
    can_issue = (state == EMPTY) || bus.rsp_ready;
    contested = bus.a_valid && bus.b_valid;
    grant_a   = !rst && can_issue && bus.a_valid && (!bus.b_valid || !prio);
    grant_b   = !rst && can_issue && bus.b_valid && (!bus.a_valid ||  prio);
    grant     = grant_a || grant_b;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (bus.rsp_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign sel_d_p0 = grant_b ? bus.b_d : bus.a_d;
  assign sel_s_p0 = grant_b ? bus.b_s : bus.a_s;
  assign sel_t_p0 = grant_b ? bus.b_t : bus.a_t;
  assign shift_p0 = barrel_shift(sel_d_p0, sel_s_p0, sel_t_p0);

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Stage p1: response buffer; prio moves to the loser only on a contested grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      prio  <= 1'b0;
      q_p1  <= 8'h00;
      id_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant && contested) prio <= ~prio;
      if (grant) begin
        q_p1  <= shift_p0;
        id_p1 <= grant_b;
      end
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_q     = q_p1;
  assign bus.rsp_id    = id_p1;

`ifdef SHIFT_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_grants <= '0;
      b_grants <= '0;
    end else begin
      if (grant_a) a_grants <= sat_inc(a_grants);
      if (grant_b) b_grants <= sat_inc(b_grants);
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: vector table for single-cycle behaviour plus
// hand-written sequences for reset, back-to-back contention and (with SHIFT_STATS_EN) counters.
module tb_shift_arbiter;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  shift_arbiter_if bus ();

`ifdef SHIFT_STATS_EN
  logic [3:0] a_grants;
  logic [3:0] b_grants;
  shift_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .a_grants(a_grants), .b_grants(b_grants)
  );
`else
  shift_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic [2:0] as_;
    logic [1:0] at;
    logic       bv;
    logic [7:0] bd;
    logic [2:0] bs;
    logic [1:0] bt;
    logic       rr;
    logic       exp_ar;
    logic       exp_br;
    logic       exp_rv;
    logic [7:0] exp_q;
    logic       exp_id;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [7:0] ad, input logic [2:0] as_,
                       input logic [1:0] at, input logic bv, input logic [7:0] bd,
                       input logic [2:0] bs, input logic [1:0] bt, input logic rr);
    bus.a_valid = av; bus.a_d = ad; bus.a_s = as_; bus.a_t = at;
    bus.b_valid = bv; bus.b_d = bd; bus.b_s = bs; bus.b_t = bt;
    bus.rsp_ready = rr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 8'h00, 3'd0, 2'b00, 0, 8'h00, 3'd0, 2'b00, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //           av ad     as    at     bv bd     bs    bt     rr ar br rv q      id
    vecs[0]  = '{1, 8'h96, 3'd2, 2'b01, 0, 8'h00, 3'd0, 2'b00, 1, 1, 0, 1, 8'hE5, 0};
    vecs[1]  = '{0, 8'h00, 3'd0, 2'b00, 1, 8'h96, 3'd2, 2'b00, 1, 0, 1, 1, 8'h25, 1};
    vecs[2]  = '{0, 8'h00, 3'd0, 2'b00, 1, 8'h96, 3'd3, 2'b10, 1, 0, 1, 1, 8'hB0, 1};
    vecs[3]  = '{0, 8'h00, 3'd0, 2'b00, 1, 8'h96, 3'd0, 2'b01, 1, 0, 1, 1, 8'h96, 1};
    vecs[4]  = '{0, 8'h00, 3'd0, 2'b00, 1, 8'h81, 3'd1, 2'b11, 1, 0, 1, 1, 8'h02, 1};
    vecs[5]  = '{1, 8'h81, 3'd7, 2'b00, 0, 8'h00, 3'd0, 2'b00, 1, 1, 0, 1, 8'h01, 0};
    vecs[6]  = '{1, 8'h80, 3'd7, 2'b01, 0, 8'h00, 3'd0, 2'b00, 1, 1, 0, 1, 8'hFF, 0};
    vecs[7]  = '{0, 8'h00, 3'd0, 2'b00, 0, 8'h00, 3'd0, 2'b00, 1, 0, 0, 0, 8'hFF, 0};
    vecs[8]  = '{1, 8'h01, 3'd1, 2'b10, 1, 8'h01, 3'd2, 2'b10, 1, 1, 0, 1, 8'h02, 0};
    vecs[9]  = '{1, 8'h01, 3'd1, 2'b10, 1, 8'h01, 3'd2, 2'b10, 1, 0, 1, 1, 8'h04, 1};
    vecs[10] = '{1, 8'h01, 3'd1, 2'b10, 1, 8'h01, 3'd2, 2'b10, 1, 1, 0, 1, 8'h02, 0};
    vecs[11] = '{1, 8'h01, 3'd1, 2'b10, 1, 8'h01, 3'd2, 2'b10, 0, 0, 0, 1, 8'h02, 0};
    vecs[12] = '{1, 8'h01, 3'd1, 2'b10, 1, 8'h01, 3'd2, 2'b10, 0, 0, 0, 1, 8'h02, 0};
    vecs[13] = '{1, 8'h01, 3'd1, 2'b10, 1, 8'h01, 3'd2, 2'b10, 0, 0, 0, 1, 8'h02, 0};
    vecs[14] = '{1, 8'h01, 3'd1, 2'b10, 1, 8'h01, 3'd2, 2'b10, 1, 0, 1, 1, 8'h04, 1};
    vecs[15] = '{0, 8'h00, 3'd0, 2'b00, 1, 8'h01, 3'd2, 2'b10, 1, 0, 1, 1, 8'h04, 1};
    vecs[16] = '{1, 8'h01, 3'd1, 2'b10, 1, 8'h01, 3'd2, 2'b10, 1, 1, 0, 1, 8'h02, 0};

    rst = 1'b1;
    drive(0, 8'h00, 3'd0, 2'b00, 0, 8'h00, 3'd0, 2'b00, 0);
    #2;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_q", 32'(bus.rsp_q), 32'h00);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    check("reset_a_ready", 32'(bus.a_ready), 32'd0);
    check("reset_b_ready", 32'(bus.b_ready), 32'd0);
    do_reset();

    // Table: drive, check combinational readies, clock, check registered response.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].av, vecs[i].ad, vecs[i].as_, vecs[i].at,
            vecs[i].bv, vecs[i].bd, vecs[i].bs, vecs[i].bt, vecs[i].rr);
      #1;
      check($sformatf("v%0d_a_ready", i), 32'(bus.a_ready), 32'(vecs[i].exp_ar));
      check($sformatf("v%0d_b_ready", i), 32'(bus.b_ready), 32'(vecs[i].exp_br));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].exp_rv));
      check($sformatf("v%0d_rsp_q", i), 32'(bus.rsp_q), 32'(vecs[i].exp_q));
      check($sformatf("v%0d_rsp_id", i), 32'(bus.rsp_id), 32'(vecs[i].exp_id));
    end

    // Reset with a held result and both requests pending; prio is left at B first.
    do_reset();
    drive(1, 8'h01, 3'd1, 2'b10, 1, 8'h01, 3'd2, 2'b10, 1);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("async_rst_rsp_q", 32'(bus.rsp_q), 32'h00);
    check("async_rst_a_ready", 32'(bus.a_ready), 32'd0);
    check("async_rst_b_ready", 32'(bus.b_ready), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check("post_rst_a_ready", 32'(bus.a_ready), 32'd1);
    check("post_rst_b_ready", 32'(bus.b_ready), 32'd0);

    // Continuous contention: one result per cycle, ids alternating from A.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rr%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("rr%0d_rsp_id", i), 32'(bus.rsp_id), 32'(i % 2));
      check($sformatf("rr%0d_rsp_q", i), 32'(bus.rsp_q), (i % 2 == 0) ? 32'h02 : 32'h04);
    end

`ifdef SHIFT_STATS_EN
    do_reset();
    check("stats_reset_a", 32'(a_grants), 32'd0);
    check("stats_reset_b", 32'(b_grants), 32'd0);
    drive(1, 8'h11, 3'd1, 2'b00, 0, 8'h00, 3'd0, 2'b00, 1);
    repeat (20) @(posedge clk);
    #1;
    check("stats_a_sat", 32'(a_grants), 32'd15);
    check("stats_b_zero", 32'(b_grants), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
